// File: rtl/frame_manchester_tx.sv
// -----------------------------------------------------------------------------
// frame_manchester_tx
//
// Takes completed Hamming-encoded frames from the frame builder, buffers them
// in a small frame FIFO, and sends each one LSB-first as IEEE-convention
// Manchester code. Line timing comes from an external half-bit strobe.
//
// Handshake: a frame is offered by pulsing frame_valid for one cycle, with
// frame_in valid in that cycle. It is stored when accept is high, or when
// the transmitter pops the FIFO head in the same cycle. Any other offer is
// dropped and sets the sticky overflow flag. accept is combinational and
// follows fifo_count only, so upstream can use it as a plain enable.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   frame_in     FW-bit encoded frame; byte 0 is bits [7:0] and goes out first
//   frame_valid  one-cycle push strobe for frame_in
//   half_tick    one-cycle strobe per Manchester half-bit period
//   accept       high when a push in this cycle would be stored
//   man_out      registered Manchester line output
//   tx_active    high while a frame is on the line
//   sof          one-cycle pulse when bit 0 of a frame is launched
//   eof          one-cycle pulse when the last half-bit of a frame completes
//   fifo_count   stored frames not yet launched (excludes the one shifting)
//   overflow     sticky; set when a frame is dropped, cleared only by rst
// -----------------------------------------------------------------------------
module frame_manchester_tx #(
  parameter int MAX_BYTES  = 12,
  // Number of frame slots; must be a power of 2 and at least 2 so that the
  // read/write pointers wrap naturally.
  parameter int FIFO_DEPTH = 2,
  localparam int FW = 8 * MAX_BYTES,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int BW = $clog2(FW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [FW-1:0] frame_in,
  input  logic          frame_valid,
  input  logic          half_tick,
  output logic          accept,
  output logic          man_out,
  output logic          tx_active,
  output logic          sof,
  output logic          eof,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  // ---------------------------------------------------------------------------
  // Transmit FSM states
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  logic [0:0]    state;
  logic          phase;      // 0 = first half of the current bit on the line
  logic [BW-1:0] bit_cnt;    // index of the bit currently on the line
  logic [FW-1:0] shreg;      // shreg[0] is the bit currently on the line

  // ---------------------------------------------------------------------------
  // Frame FIFO storage
  // ---------------------------------------------------------------------------
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          fifo_nonempty;
  logic          frame_done;
  logic          pop;
  logic          push;
  logic [FW-1:0] head;

  always_comb begin
    fifo_nonempty = (count != '0);
    // Last half-bit of the frame is on the line and this strobe ends it.
    frame_done    = (state == ST_SEND) && phase && (bit_cnt == LAST_BIT);
    // A pop only ever looks at the registered count, so a frame pushed in
    // this same cycle is never popped before it has been written.
    pop           = half_tick && fifo_nonempty &&
                    ((state == ST_IDLE) || frame_done);
    accept        = (count < DEPTH_C);
    // When full, a simultaneous pop frees the slot being read, which is the
    // slot wr_ptr points at; the read below sees the old contents.
    push          = frame_valid && (accept || pop);
    head          = mem[rd_ptr];
  end

  assign fifo_count = count;

  // Storage array is not reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= frame_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (frame_valid && !push) begin
      overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer / Manchester encoder
  //   IEEE convention: bit 1 -> 0 then 1, bit 0 -> 1 then 0.
  //   So the first half is the inverted bit and the second half is the bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      man_out   <= 1'b0;
      tx_active <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      sof <= 1'b0;
      eof <= 1'b0;
      if (half_tick) begin
        unique case (state)
          ST_IDLE: begin
            if (pop) begin
              shreg     <= head;
              man_out   <= ~head[0];
              sof       <= 1'b1;
              tx_active <= 1'b1;
              phase     <= 1'b0;
              bit_cnt   <= '0;
              state     <= ST_SEND;
            end
          end
          ST_SEND: begin
            if (!phase) begin
              man_out <= shreg[0];
              phase   <= 1'b1;
            end else if (bit_cnt != LAST_BIT) begin
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BW'(1);
              man_out <= ~shreg[1];
              phase   <= 1'b0;
            end else begin
              eof <= 1'b1;
              if (pop) begin
                // Back-to-back: next frame's bit 0 starts on this same edge.
                shreg     <= head;
                man_out   <= ~head[0];
                sof       <= 1'b1;
                tx_active <= 1'b1;
                phase     <= 1'b0;
                bit_cnt   <= '0;
              end else begin
                man_out   <= 1'b0;
                tx_active <= 1'b0;
                phase     <= 1'b0;
                bit_cnt   <= '0;
                state     <= ST_IDLE;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count <= DEPTH_C);
  a_sof_active : assert property (@(posedge clk) disable iff (rst)
    sof |-> tx_active);
  a_idle_line : assert property (@(posedge clk) disable iff (rst)
    !tx_active |-> !man_out);

endmodule

// File: tb/tb_frame_manchester_tx.sv
// -----------------------------------------------------------------------------
// tb_frame_manchester_tx
//
// Directed bench for frame_manchester_tx (MAX_BYTES=12, FIFO_DEPTH=2).
// A line monitor records one half-bit per strobe while tx_active is high,
// decodes each completed frame and compares it with the expected queue.
// -----------------------------------------------------------------------------
module tb_frame_manchester_tx;

  localparam int MAX_BYTES  = 12;
  localparam int FIFO_DEPTH = 2;
  localparam int FW         = 8 * MAX_BYTES;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] frame_in;
  logic          frame_valid;
  logic          half_tick;
  logic          accept;
  logic          man_out;
  logic          tx_active;
  logic          sof;
  logic          eof;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  always #5 clk = ~clk;

  frame_manchester_tx #(
    .MAX_BYTES  (MAX_BYTES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .half_tick   (half_tick),
    .accept      (accept),
    .man_out     (man_out),
    .tx_active   (tx_active),
    .sof         (sof),
    .eof         (eof),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [FW-1:0] exp_q[$];
  int            frames_seen = 0;
  int            tick_ctr    = 0;

  task automatic check_eq(input string tag, input logic [FW-1:0] got,
                          input logic [FW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line monitor: one half-bit per strobe edge while tx_active; sof restarts.
  // ---------------------------------------------------------------------------
  logic          h [2*FW];
  int            hidx = 0;
  logic          tick_seen = 1'b0;
  logic [FW-1:0] dec_word;
  int            dec_bad;

  always @(posedge clk) tick_seen <= half_tick;

  always @(negedge clk) begin
    if (tick_seen && tx_active) begin
      if (sof) hidx = 0;
      if (hidx < 2*FW) begin
        h[hidx] = man_out;
        hidx++;
        if (hidx == 2*FW) begin
          dec_bad = 0;
          for (int i = 0; i < FW; i++) begin
            dec_word[i] = h[2*i+1];
            if (h[2*i] == h[2*i+1]) dec_bad++;
          end
          check_eq("manchester_pairs", dec_bad, 0);
          if (exp_q.size() == 0) check_eq("unexpected_frame", 1, 0);
          else check_eq("frame_data", dec_word, exp_q.pop_front());
          frames_seen++;
          hidx++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change 1 time unit after the rising edge; outputs are
  // checked at that same point, after the edge has settled.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic push, input logic [FW-1:0] f,
                       input logic tick);
    frame_valid = push;
    frame_in    = f;
    half_tick   = tick;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    half_tick   = 1'b0;
  endtask

  function automatic logic tick_due(input int period);
    return (period <= 1) ? 1'b1 : ((tick_ctr % period) == 0);
  endfunction

  task automatic run_ticks(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, '0, tick_due(period));
      tick_ctr++;
    end
  endtask

  // sel 0: stop on sof, sel 1: stop on eof
  task automatic run_until(input int sel, input int period, input int budget);
    int   i;
    logic found;
    i = 0;
    found = 1'b0;
    while (!found && i < budget) begin
      cycle(1'b0, '0, tick_due(period));
      tick_ctr++;
      i++;
      found = (sel == 0) ? sof : eof;
    end
    check_eq((sel == 0) ? "sof_timeout" : "eof_timeout", found, 1'b1);
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || tx_active) && i < budget) begin
      cycle(1'b0, '0, 1'b1);
      i++;
    end
    check_eq("drain_timeout", (i < budget), 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_man_out"},    man_out,    1'b0);
    check_eq({tag, "_tx_active"},  tx_active,  1'b0);
    check_eq({tag, "_sof"},        sof,        1'b0);
    check_eq({tag, "_eof"},        eof,        1'b0);
    check_eq({tag, "_overflow"},   overflow,   1'b0);
    check_eq({tag, "_fifo_count"}, fifo_count, '0);
    check_eq({tag, "_accept"},     accept,     1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [FW-1:0] FR_ONE = 96'h1;
  localparam logic [FW-1:0] FR_A   = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [FW-1:0] FR_B   = 96'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
  localparam logic [FW-1:0] FR_C   = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
  localparam logic [FW-1:0] FR_D   = 96'hFEDC_BA98_7654_3210_C3C3_3C3C;
  localparam logic [FW-1:0] FR_E   = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
  localparam logic [FW-1:0] FR_F   = 96'h8000_0000_0000_0000_0000_0002;

  initial begin
    int            sof_cnt;
    int            w;
    logic [FW-1:0] rnd;

    rst         = 1'b1;
    frame_valid = 1'b0;
    half_tick   = 1'b0;
    frame_in    = '0;
    repeat (3) cycle(1'b0, '0, 1'b0);
    check_reset_values("reset");
    rst = 1'b0;

    // ---- single frame, strobe every 4 clocks ----
    cycle(1'b1, FR_ONE, 1'b0);
    exp_q.push_back(FR_ONE);
    check_eq("single_count_after_push", fifo_count, 1);
    check_eq("single_idle_before_tick", tx_active, 1'b0);
    run_until(0, 4, 16);
    check_eq("single_first_half", man_out, 1'b0);
    check_eq("single_count_at_launch", fifo_count, 0);
    run_until(1, 4, 2000);
    check_eq("single_end_tx_active", tx_active, 1'b0);
    check_eq("single_end_man_out", man_out, 1'b0);
    check_eq("single_h0", h[0], 1'b0);
    check_eq("single_h1", h[1], 1'b1);
    check_eq("single_h2", h[2], 1'b1);
    check_eq("single_h3", h[3], 1'b0);
    check_eq("single_h_last", h[2*FW-1], 1'b0);

    // ---- back-to-back with simultaneous push/pop, then overflow ----
    cycle(1'b1, FR_A, 1'b0);
    exp_q.push_back(FR_A);
    check_eq("b2b_count_1", fifo_count, 1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, FR_B, 1'b0);
    exp_q.push_back(FR_B);
    check_eq("b2b_count_2", fifo_count, 2);
    check_eq("b2b_accept_full", accept, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check_eq("b2b_a_sof", sof, 1'b1);
    check_eq("b2b_count_at_launch", fifo_count, 1);
    check_eq("b2b_a_first_half", man_out, 1'b0);
    cycle(1'b1, FR_C, 1'b0);
    exp_q.push_back(FR_C);
    check_eq("b2b_count_full", fifo_count, 2);
    run_ticks(2*FW - 1, 1);
    check_eq("b2b_no_early_eof", eof, 1'b0);
    check_eq("b2b_still_active", tx_active, 1'b1);
    cycle(1'b1, FR_D, 1'b1);
    exp_q.push_back(FR_D);
    check_eq("simul_eof", eof, 1'b1);
    check_eq("simul_sof_with_eof", sof, 1'b1);
    check_eq("simul_overflow", overflow, 1'b0);
    check_eq("simul_count", fifo_count, 2);
    check_eq("simul_b_first_half", man_out, 1'b1);
    check_eq("simul_tx_active", tx_active, 1'b1);
    check_eq("ovf_accept_before", accept, 1'b0);
    cycle(1'b1, FR_E, 1'b0);
    check_eq("ovf_flag", overflow, 1'b1);
    check_eq("ovf_count", fifo_count, 2);
    run_ticks(10, 1);
    check_eq("ovf_sticky", overflow, 1'b1);
    drain(3000);
    check_eq("ovf_sticky_after_drain", overflow, 1'b1);

    // ---- reset in the middle of a frame ----
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0);
    rst = 1'b0;
    check_eq("rst_clears_overflow", overflow, 1'b0);
    cycle(1'b1, FR_F, 1'b0);
    exp_q.push_back(FR_F);
    cycle(1'b0, '0, 1'b1);
    check_eq("mid_sof", sof, 1'b1);
    cycle(1'b1, FR_B, 1'b0);
    check_eq("mid_count", fifo_count, 1);
    run_ticks(80, 1);
    check_eq("mid_active_bit40", tx_active, 1'b1);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    check_reset_values("mid_reset");
    sof_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (sof) sof_cnt++;
    end
    check_eq("mid_no_sof_after_reset", sof_cnt, 0);
    check_eq("mid_idle_after_reset", tx_active, 1'b0);

    // ---- random frames, strobe every cycle ----
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!accept && w < 1000) begin
        cycle(1'b0, '0, 1'b1);
        w++;
      end
      check_eq("sweep_accept_timeout", (w < 1000), 1'b1);
      rnd = {$urandom, $urandom, $urandom};
      cycle(1'b1, rnd, 1'b1);
      exp_q.push_back(rnd);
    end
    drain(3000);
    check_eq("frames_decoded", frames_seen, 9);
    check_eq("final_overflow", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
